// File: rtl/text_tile_gen_if.sv
`timescale 1ns/1ps
// Pixel-position, host-write and cursor signals shared by text_tile_gen and its driver.
// master drives pixels/host commands; slave (the generator) returns cursor and pixel colour.
interface text_tile_gen_if;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       blink_tick;
  logic       wr_en;
  logic [6:0] wr_char;
  logic [2:0] wr_color;
  logic       cur_set;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic       text_on;
  logic [2:0] rgb_text;

  modport master (
    output video_on, pixel_x, pixel_y, blink_tick, wr_en, wr_char, wr_color,
           cur_set, cur_x, cur_y,
    input  cur_col, cur_row, text_on, rgb_text
  );

  modport slave (
    input  video_on, pixel_x, pixel_y, blink_tick, wr_en, wr_char, wr_color,
           cur_set, cur_x, cur_y,
    output cur_col, cur_row, text_on, rgb_text
  );
endinterface

// File: rtl/text_tile_gen.sv
`timescale 1ns/1ps
// Character-cell text renderer with host cursor and blinking inverse cursor cell.
// Fixed 3-clk latency pixel-in to rgb_text/text_on; no backpressure, one pixel per clk.
module text_tile_gen #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int FONT_H_LOG2  = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic           clk,
  input  logic           reset_n,
  text_tile_gen_if.slave bus
);
  localparam int              FH         = FONT_H_LOG2;
  localparam int              BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]      COL_MAX    = 7'(COLS - 1);
  localparam logic [4:0]      ROW_MAX    = 5'(ROWS - 1);
  localparam logic [10:0]     COLS_L     = 11'(COLS);
  localparam logic [9:0]      ROWS_L     = 10'(ROWS);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [127:0]    GLYPH_A    = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
  localparam logic [127:0]    GLYPH_Z    = 128'h0000_FEC6_8C18_3060_C2C6_FE00_0000_0000;

  // Glyph line 0 is the top scanline; bit 7 of a line is the leftmost pixel.
  function automatic logic [7:0] glyph(input logic [6:0] ch, input logic [3:0] ln);
    logic [6:0] base;
    base = {4'd15 - ln, 3'b000};
    case (ch)
      7'h20:   glyph = 8'h00;
      7'h41:   glyph = GLYPH_A[base +: 8];
      7'h5A:   glyph = GLYPH_Z[base +: 8];
      default: glyph = (ln < 4'd2 || ln > 4'd13) ? 8'h00 : ({1'b0, ch} ^ {ln, ln});
    endcase
  endfunction

  logic [6:0]    cur_col_q;
  logic [4:0]    cur_row_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [6:0] s0_col;
  logic [9:0] s0_row;
  logic       s0_in_area;
  logic       s0_is_cur;

  assign s0_col     = bus.pixel_x[9:3];
  assign s0_row     = bus.pixel_y >> FH;
  assign s0_in_area = ({4'd0, s0_col} < COLS_L) && (s0_row < ROWS_L);
  assign s0_is_cur  = (s0_col == cur_col_q) && (s0_row == {5'd0, cur_row_q});

  // Non-blocking read alongside the write gives read-first behaviour on collisions.
  logic [9:0] buf_mem [0:4095];
  logic [9:0] ram_q;
  always_ff @(posedge clk) begin
    if (bus.wr_en) buf_mem[{cur_row_q, cur_col_q}] <= {bus.wr_color, bus.wr_char};
    ram_q <= buf_mem[{s0_row[4:0], s0_col}];
  end

  logic          s1_vld, s1_in, s1_cur;
  logic [2:0]    s1_bit;
  logic [FH-1:0] s1_line;
  logic [7:0]    rom_q;

  always_ff @(posedge clk) rom_q <= glyph(ram_q[6:0], 4'(s1_line));

  logic       s2_vld, s2_in, s2_cur;
  logic [2:0] s2_bit;
  logic [2:0] s2_color;
  logic       font_bit, lit;
  logic       text_on_q;
  logic [2:0] rgb_q;

  assign font_bit = rom_q[~s2_bit];
  assign lit      = font_bit ^ (s2_cur & blink_phase);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld    <= 1'b0;
      s1_in     <= 1'b0;
      s1_cur    <= 1'b0;
      s1_bit    <= '0;
      s1_line   <= '0;
      s2_vld    <= 1'b0;
      s2_in     <= 1'b0;
      s2_cur    <= 1'b0;
      s2_bit    <= '0;
      s2_color  <= '0;
      text_on_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      s1_vld   <= bus.video_on;
      s1_in    <= s0_in_area;
      s1_cur   <= s0_is_cur;
      s1_bit   <= bus.pixel_x[2:0];
      s1_line  <= bus.pixel_y[FH-1:0];
      s2_vld   <= s1_vld;
      s2_in    <= s1_in;
      s2_cur   <= s1_cur;
      s2_bit   <= s1_bit;
      s2_color <= ram_q[9:7];
      if (s2_vld && s2_in && lit) begin
        text_on_q <= 1'b1;
        rgb_q     <= s2_color;
      end else begin
        text_on_q <= 1'b0;
        rgb_q     <= '0;
      end
    end
  end

  // cur_set wins over the post-write advance; the write itself still uses the old cursor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_col_q <= '0;
      cur_row_q <= '0;
    end else if (bus.cur_set) begin
      cur_col_q <= (bus.cur_x > COL_MAX) ? COL_MAX : bus.cur_x;
      cur_row_q <= (bus.cur_y > ROW_MAX) ? ROW_MAX : bus.cur_y;
    end else if (bus.wr_en) begin
      if (cur_col_q == COL_MAX) begin
        cur_col_q <= '0;
        cur_row_q <= (cur_row_q == ROW_MAX) ? 5'd0 : cur_row_q + 5'd1;
      end else begin
        cur_col_q <= cur_col_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.blink_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign bus.cur_col  = cur_col_q;
  assign bus.cur_row  = cur_row_q;
  assign bus.text_on  = text_on_q;
  assign bus.rgb_text = rgb_q;
endmodule

// File: doc/text_tile_gen.md
Name: text_tile_gen

Overview:
- Parametrised successor to the fixed font test pattern generator.
- Holds a writable character/colour buffer of COLS x ROWS cells and renders it through the synchronous font ROM with per-cell 3-bit foreground colour.
- Provides a host cursor with auto-advance and wrap, plus a blinking inverse-video cursor cell.
- Sits between vga_sync (pixel_x, pixel_y, video_on) and the RGB output mux.

Parameters:
- COLS, 80, text columns rendered (1..128)
- ROWS, 30, text rows rendered (1..32)
- FONT_H_LOG2, 4, log2 of glyph height in pixels; glyph width fixed at 8
- BLINK_FRAMES, 30, blink_tick pulses per cursor blink half-period (>=1)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- video_on  in  1  visible-area flag from vga_sync
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- blink_tick  in  1  one-cycle pulse per frame
- wr_en  in  1  write wr_char/wr_color at cursor, then advance cursor
- wr_char  in  7  ASCII code to write
- wr_color  in  3  foreground colour for the written cell
- cur_set  in  1  load cursor from cur_x/cur_y
- cur_x  in  7  new cursor column
- cur_y  in  5  new cursor row
- cur_col  out  7  current cursor column
- cur_row  out  5  current cursor row
- text_on  out  1  registered: a lit pixel (fg) is being driven
- rgb_text  out  3  registered pixel colour

Behaviour:
- Reset (async, reset_n=0):
  - cur_col=0, cur_row=0.
  - Blink counter and blink phase = 0.
  - Pipeline valid/control registers = 0.
  - rgb_text=000, text_on=0.
- Buffer RAM is not cleared by reset; contents are undefined until written.
- Buffer organisation:
  - 4096 x 10 bits, address {row[4:0], col[6:0]}, data {color[2:0], char[6:0]}.
  - One synchronous write port and one synchronous read port.
- Render pipeline (fixed latency 3 clk from pixel inputs to rgb_text/text_on):
  - S0: col = pixel_x[9:3], row = pixel_y >> FONT_H_LOG2. Register the RAM read address, bit = pixel_x[2:0], line = pixel_y[FONT_H_LOG2-1:0], video_on, in_area = (col<COLS && row<ROWS), and is_cur = (col==cur_col && row==cur_row).
  - S1: RAM data valid. Font ROM address = {char, line}. Carry colour and control bits forward.
  - S2: ROM word valid. Pixel bit = font_word[~bit]. Compute the output and register it at the end of S2.
- Output rule (evaluated on S2 data):
  - If !video_on or !in_area: rgb=000, text_on=0.
  - Otherwise lit = font_bit XOR (is_cur AND blink_phase).
  - If lit: rgb=color, text_on=1; else rgb=000, text_on=0.
- Write and cursor:
  - wr_en=1: the cell at the current (cur_row, cur_col) is written on that edge.
  - Then col+1; if col==COLS-1 then col=0 and row+1; if row==ROWS-1 then row wraps to 0.
- cur_set=1:
  - Loads cursor = (min(cur_x, COLS-1), min(cur_y, ROWS-1)).
- cur_set and wr_en in the same cycle:
  - The write goes to the old cursor position.
  - The cursor takes the cur_set value; no advance.
- Write and render collision:
  - A write and a render read of the same address in the same cycle returns the old data (read-first).
  - The new data is visible from the next read.
- Blink:
  - On blink_tick, the counter increments.
  - When counter==BLINK_FRAMES-1 and blink_tick=1: counter=0 and blink_phase toggles.
  - BLINK_FRAMES=1 toggles on every tick.
- Pixels with pixel_x>=640 or pixel_y>=480 arrive with video_on=0 and produce black.
- Reset mid-frame: outputs go to 000/0 immediately and stay there for 3 clk after release, until the pipeline refills. Buffer contents are retained.

Test Plan:
- Reset: assert reset_n=0 mid-render -> rgb_text=000, text_on=0, cur_col=0, cur_row=0 asynchronously; after release, first non-black output no earlier than 3 clk.
- Single write: wr_en, wr_char=0x41, wr_color=010 at (0,0); sweep pixel_y=0..15, pixel_x=0..7 -> rgb matches the 'A' glyph bits in green, exactly 3 clk after each input; cur_col=1.
- Wrap: cur_set to (79,29), then one wr_en -> cell (29,79) written; cursor=(0,0). cur_set (120,31) -> cursor=(79,29) (clamped).
- Simultaneous: cur_set (5,3) with wr_en (char 0x5A) while cursor=(10,2) -> cell (2,10)='Z'; cursor=(5,3).
- Blink: BLINK_FRAMES=2, cursor on a blank cell (char 0x20) -> cell is black after 0-1 ticks, fully colour-filled after 2 ticks, black again after 4 ticks; non-cursor cells unchanged.
- Out-of-area/blanking: COLS=40, pixel_x=320..639 -> black; video_on=0 over a lit glyph -> 000 with 3-clk alignment.
